// File: rtl/led_pattern_decoder.sv
// Passive monitor for the LED pattern bus: classifies each strobed step against the four
// generator modes, locks after LOCK_CNT consistent transitions and flags deviations.
module led_pattern_decoder #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clki,
  input  logic       rs,
  input  logic       step,
  input  logic [7:0] led,
  output logic [1:0] mode,
  output logic       locked,
  output logic       err,
  output logic [3:0] match_cnt
);

  localparam logic [1:0] StEmpty  = 2'd0;
  localparam logic [1:0] StTrack  = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam logic [3:0]  LockCnt    = 4'(LOCK_CNT);
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  prev_q, prev_d;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  mode_q, mode_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;

  logic        prev_onehot;
  logic [3:0]  mask;
  logic [1:0]  rst_cand;
  logic [3:0]  rst_cnt;
  logic        hit_trk;
  logic [1:0]  trk_cand;
  logic [3:0]  trk_cnt;
  logic [15:0] tmo_inc;

  assign prev_onehot = (prev_q != 8'h00) && ((prev_q & (prev_q - 8'd1)) == 8'h00);

  // One mask bit per generator mode; FF->00 legitimately sets both blink and fill.
  assign mask[0] = prev_onehot && (led == {prev_q[6:0], prev_q[7]});
  assign mask[1] = prev_onehot && (led == {prev_q[0], prev_q[7:1]});
  assign mask[2] = ((prev_q == 8'h00) && (led == 8'hFF)) || ((prev_q == 8'hFF) && (led == 8'h00));
  assign mask[3] = ((prev_q != 8'hFF) && (led == {prev_q[6:0], 1'b1})) ||
                   ((prev_q == 8'hFF) && (led == 8'h00));

  always_comb begin
    rst_cand = 2'd3;
    if (mask[0])      rst_cand = 2'd0;
    else if (mask[1]) rst_cand = 2'd1;
    else if (mask[2]) rst_cand = 2'd2;
  end

  assign rst_cnt  = (mask != 4'b0000) ? 4'd1 : 4'd0;
  assign hit_trk  = (cnt_q != 4'd0) && mask[cand_q];
  assign trk_cand = hit_trk ? cand_q : rst_cand;
  assign trk_cnt  = hit_trk ? (cnt_q + 4'd1) : rst_cnt;
  assign tmo_inc  = tmo_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cand_d   = cand_q;
    mode_d   = mode_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      StEmpty: begin
        if (step) begin
          prev_d  = led;
          state_d = StTrack;
        end
      end
      StTrack: begin
        if (step) begin
          prev_d = led;
          cand_d = trk_cand;
          cnt_d  = trk_cnt;
          if (trk_cnt == LockCnt) begin
            state_d  = StLocked;
            mode_d   = trk_cand;
            locked_d = 1'b1;
            tmo_d    = 16'd0;
          end
        end
      end
      StLocked: begin
        if (step) begin
          prev_d = led;
          tmo_d  = 16'd0;
          if (!mask[mode_q]) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = StTrack;
            cand_d   = rst_cand;
            cnt_d    = rst_cnt;
            // Only reachable with LOCK_CNT=1: relock at once, error still reported.
            if (rst_cnt == LockCnt) begin
              state_d  = StLocked;
              locked_d = 1'b1;
              mode_d   = rst_cand;
            end
          end
        end else begin
          tmo_d = tmo_inc;
          if ((TimeoutVal != 16'd0) && (tmo_inc == TimeoutVal)) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = StEmpty;
            tmo_d    = 16'd0;
          end
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clki) begin
    if (rs) begin
      state_q  <= StEmpty;
      prev_q   <= 8'h00;
      cand_q   <= 2'd0;
      mode_q   <= 2'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 4'd0;
      tmo_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cand_q   <= cand_d;
      mode_q   <= mode_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign mode      = mode_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed bench for led_pattern_decoder: a table of per-cycle vectors with hand-computed
// expected outputs, followed by hand-written timeout sequences.
module tb_led_pattern_decoder;

  logic       clki;
  logic       rs;
  logic       step;
  logic [7:0] led;
  logic [1:0] mode;
  logic       locked;
  logic       err;
  logic [3:0] match_cnt;

  int checks;
  int failures;

  led_pattern_decoder #(
    .LOCK_CNT(4),
    .TIMEOUT (20)
  ) dut (
    .clki     (clki),
    .rs       (rs),
    .step     (step),
    .led      (led),
    .mode     (mode),
    .locked   (locked),
    .err      (err),
    .match_cnt(match_cnt)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  typedef struct {
    logic       rs;
    logic       step;
    logic [7:0] led;
    logic [3:0] cnt;
    logic       locked;
    logic [1:0] mode;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic [7:0] l,
                              input logic [3:0] c, input logic lk, input logic [1:0] m,
                              input logic e);
    vec_t v;
    v.rs = r; v.step = s; v.led = l; v.cnt = c; v.locked = lk; v.mode = m; v.err = e;
    vecs.push_back(v);
  endfunction

  // One clock: drive on the falling edge, sample 1ns after the rising edge.
  task automatic cycle(input logic r, input logic s, input logic [7:0] l);
    @(negedge clki);
    rs   = r;
    step = s;
    led  = l;
    @(posedge clki);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] c, input logic lk,
                       input logic [1:0] m, input logic e);
    checks++;
    if (match_cnt !== c || locked !== lk || mode !== m || err !== e) begin
      failures++;
      $display("FAIL %s: got cnt=%0d locked=%0b mode=%0d err=%0b, want cnt=%0d locked=%0b mode=%0d err=%0b",
               name, match_cnt, locked, mode, err, c, lk, m, e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rs       = 1'b1;
    step     = 1'b0;
    led      = 8'h00;

    // Reset, rotate-left lock, rotate through wrap to 01, then mismatch 01->03 (fill).
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h01, 0, 0, 0, 0);
    add(0, 1, 8'h02, 1, 0, 0, 0);
    add(0, 1, 8'h04, 2, 0, 0, 0);
    add(0, 1, 8'h08, 3, 0, 0, 0);
    add(0, 1, 8'h10, 4, 1, 0, 0);
    add(0, 1, 8'h20, 4, 1, 0, 0);
    add(0, 1, 8'h40, 4, 1, 0, 0);
    add(0, 1, 8'h80, 4, 1, 0, 0);
    add(0, 1, 8'h01, 4, 1, 0, 0);
    add(0, 1, 8'h03, 1, 0, 0, 1);
    add(0, 0, 8'h03, 1, 0, 0, 0);
    add(0, 1, 8'h07, 2, 0, 0, 0);
    // Rotate-right with wrap 01->80, then reset mid-lock with a step alongside rs.
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h02, 0, 0, 0, 0);
    add(0, 1, 8'h01, 1, 0, 0, 0);
    add(0, 1, 8'h80, 2, 0, 0, 0);
    add(0, 1, 8'h40, 3, 0, 0, 0);
    add(0, 1, 8'h20, 4, 1, 1, 0);
    add(1, 1, 8'h01, 0, 0, 0, 0);
    add(0, 1, 8'h02, 0, 0, 0, 0);
    add(0, 1, 8'h04, 1, 0, 0, 0);
    // Blink: FF->00 sets both m2 and m3, lowest bit picks blink.
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 1, 0, 0, 0);
    add(0, 1, 8'h00, 2, 0, 0, 0);
    add(0, 1, 8'hFF, 3, 0, 0, 0);
    add(0, 1, 8'h00, 4, 1, 2, 0);
    add(0, 1, 8'h00, 0, 0, 2, 1);
    // Fill stays locked through FF->00.
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h01, 1, 0, 0, 0);
    add(0, 1, 8'h03, 2, 0, 0, 0);
    add(0, 1, 8'h07, 3, 0, 0, 0);
    add(0, 1, 8'h0F, 4, 1, 3, 0);
    add(0, 1, 8'h1F, 4, 1, 3, 0);
    add(0, 1, 8'h3F, 4, 1, 3, 0);
    add(0, 1, 8'h7F, 4, 1, 3, 0);
    add(0, 1, 8'hFF, 4, 1, 3, 0);
    add(0, 1, 8'h00, 4, 1, 3, 0);
    add(0, 1, 8'h01, 4, 1, 3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rs, vecs[i].step, vecs[i].led);
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].locked, vecs[i].mode, vecs[i].err);
    end

    // Timeout: 19 idle cycles keep lock, the 20th drops it with one err pulse.
    for (int k = 1; k < 20; k++) begin
      cycle(0, 0, 8'h01);
      check($sformatf("tmo_idle%0d", k), 4, 1, 3, 0);
    end
    cycle(0, 0, 8'h01);
    check("tmo_expire", 0, 0, 3, 1);
    cycle(0, 0, 8'h01);
    check("tmo_after", 0, 0, 3, 0);
    // EMPTY: first step only reloads prev.
    cycle(0, 1, 8'h02);
    check("tmo_empty", 0, 0, 3, 0);
    cycle(0, 1, 8'h04);
    check("relock1", 1, 0, 3, 0);
    cycle(0, 1, 8'h08);
    check("relock2", 2, 0, 3, 0);
    cycle(0, 1, 8'h10);
    check("relock3", 3, 0, 3, 0);
    cycle(0, 1, 8'h20);
    check("relock4", 4, 1, 0, 0);

    // A step on the expiry edge wins and restarts the idle count.
    for (int k = 1; k < 20; k++) cycle(0, 0, 8'h20);
    check("pre_race", 4, 1, 0, 0);
    cycle(0, 1, 8'h40);
    check("race_step", 4, 1, 0, 0);
    for (int k = 1; k < 20; k++) cycle(0, 0, 8'h40);
    check("race_idle19", 4, 1, 0, 0);
    cycle(0, 0, 8'h40);
    check("race_expire", 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
